// File: rtl/barrier_scroller.sv
// barrier_scroller: three-lane scrolling barrier playfield. A tick counter
// paces the scroll; a new barrier row enters at the top on each tick. The
// run ends when the bottom row overlaps the player's lane.
module barrier_scroller #(
  parameter int ROWS     = 8,
  parameter int TICK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          player_pos,
  output logic [7:0]          cnt,
  input  logic [2:0]          barrier_in,
  output logic [3*ROWS-1:0]   field,
  output logic [1:0]          state,
  output logic                hit,
  output logic [15:0]         score
);

  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10,
    S_BAD  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [3*ROWS-1:0] field_q, field_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       score_q, score_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        lane_q, lane_d;
  logic              hit_q, hit_d;

  logic [2:0] bottom;
  logic       coll;
  logic       tick;
  logic       lane_ok;

  assign bottom  = field_q[3*ROWS-1 -: 3];
  assign coll    = |(bottom & lane_q);
  assign tick    = (tick_q == TW'(TICK_DIV - 1));
  assign lane_ok = (player_pos == 3'b001) || (player_pos == 3'b010) ||
                   (player_pos == 3'b100);

  // Next-state: start clears the run, collision beats tick, idle/over holds.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    tick_d  = tick_q;
    hit_d   = 1'b0;
    lane_d  = lane_ok ? player_pos : lane_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          field_d = '0;
          cnt_d   = '0;
          score_d = '0;
          tick_d  = '0;
          lane_d  = 3'b010;
        end
      end
      S_RUN: begin
        if (coll) begin
          // Freeze everything so the crash frame stays on screen.
          state_d = S_OVER;
          hit_d   = 1'b1;
        end else begin
          tick_d = tick ? '0 : TW'(tick_q + 1'b1);
          if (tick) begin
            field_d = {field_q[3*ROWS-4:0], barrier_in};
            cnt_d   = cnt_q + 8'd1;
            if (bottom != 3'b000 && score_q != 16'hFFFF)
              score_d = score_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      field_q <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      tick_q  <= '0;
      lane_q  <= 3'b010;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      lane_q  <= lane_d;
      hit_q   <= hit_d;
    end
  end

  assign cnt   = cnt_q;
  assign field = field_q;
  assign state = state_q;
  assign hit   = hit_q;
  assign score = score_q;

endmodule

// File: tb/tb_barrier_scroller.sv
// tb_barrier_scroller: directed scenarios plus random stimulus, every cycle
// compared against a row-array reference model of the game rules.
module tb_barrier_scroller;
  localparam int ROWS = 8;
  localparam int TD   = 4;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [2:0]        player_pos, barrier_in;
  logic [7:0]        cnt;
  logic [3*ROWS-1:0] field;
  logic [1:0]        state;
  logic              hit;
  logic [15:0]       score;

  barrier_scroller #(.ROWS(ROWS), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .player_pos(player_pos),
    .cnt(cnt), .barrier_in(barrier_in), .field(field), .state(state),
    .hit(hit), .score(score)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: rows as an array (index 0 = top), plain integers.
  int         m_st;      // 0 idle, 1 run, 2 over
  logic [2:0] m_row [ROWS];
  int         m_cnt, m_score, m_tick;
  logic [2:0] m_lane;
  bit         m_hit;
  bit         hit_seen;

  function automatic bit onehot3(input logic [2:0] v);
    return v == 3'b001 || v == 3'b010 || v == 3'b100;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++) m_row[r] = 3'b000;
    m_cnt = 0; m_score = 0; m_tick = 0; m_lane = 3'b010; m_hit = 0;
  endtask

  task automatic m_step(input logic r, input logic s, input logic [2:0] pp, input logic [2:0] b);
    logic [2:0] old_lane;
    old_lane = m_lane;
    m_hit = 0;
    if (r) begin
      m_clear(); m_st = 0;
      return;
    end
    if (onehot3(pp)) m_lane = pp;
    if (m_st != 1) begin
      if (s) begin m_clear(); m_st = 1; end
    end else if ((m_row[ROWS-1] & old_lane) != 0) begin
      m_st = 2; m_hit = 1;
    end else if (m_tick == TD - 1) begin
      if (m_row[ROWS-1] != 0 && m_score < 65535) m_score++;
      for (int k = ROWS - 1; k > 0; k--) m_row[k] = m_row[k-1];
      m_row[0] = b;
      m_cnt = (m_cnt + 1) % 256;
      m_tick = 0;
    end else begin
      m_tick++;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [2:0] pp, input logic [2:0] b);
    logic [3*ROWS-1:0] mf;
    rst = r; start = s; player_pos = pp; barrier_in = b;
    @(posedge clk);
    m_step(r, s, pp, b);
    #1;
    for (int k = 0; k < ROWS; k++) mf[3*k +: 3] = m_row[k];
    if (hit) hit_seen = 1;
    chk("state", 32'(state), 32'(m_st));
    chk("cnt",   32'(cnt),   32'(m_cnt));
    chk("field", 32'(field), 32'(mf));
    chk("score", 32'(score), 32'(m_score));
    chk("hit",   32'(hit),   32'(m_hit));
  endtask

  task automatic run(input int n, input logic [2:0] pp, input logic [2:0] b);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, pp, b);
  endtask

  initial begin
    m_clear(); m_st = 0;
    rst = 1; start = 0; player_pos = 3'b010; barrier_in = 3'b000;

    // Reset
    cyc(1, 0, 3'b010, 3'b000);
    cyc(1, 0, 3'b010, 3'b000);
    cyc(0, 0, 3'b010, 3'b000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_field", 32'(field), 32'd0);

    // Dodge: barrier on the left, player on the right
    hit_seen = 0;
    cyc(0, 1, 3'b001, 3'b100);
    run(32, 3'b001, 3'b100);
    chk("dodge_bottom", 32'(field[3*ROWS-1 -: 3]), 32'b100);
    run(4, 3'b001, 3'b100);
    chk("dodge_score", 32'(score), 32'd1);
    chk("dodge_cnt",   32'(cnt),   32'd9);
    chk("dodge_nohit", 32'(hit_seen), 32'd0);

    // Collision: player in the barrier lane; start while running is ignored
    cyc(1, 0, 3'b100, 3'b100);
    cyc(0, 1, 3'b100, 3'b100);
    cyc(0, 1, 3'b100, 3'b100);
    run(31, 3'b100, 3'b100);
    chk("coll_pre_hit", 32'(hit), 32'd0);
    run(1, 3'b100, 3'b100);
    chk("coll_hit",   32'(hit),   32'd1);
    chk("coll_state", 32'(state), 32'b10);
    chk("coll_cnt",   32'(cnt),   32'd8);
    chk("coll_score", 32'(score), 32'd0);
    run(6, 3'b100, 3'b100);
    chk("coll_frozen_cnt", 32'(cnt), 32'd8);
    chk("coll_hit_pulse",  32'(hit), 32'd0);

    // Invalid lane values keep the middle lane
    cyc(0, 1, 3'b000, 3'b010);
    run(16, 3'b000, 3'b010);
    run(17, 3'b011, 3'b010);
    chk("inval_hit",   32'(hit),   32'd1);
    chk("inval_state", 32'(state), 32'b10);

    // Wrap: 256 empty ticks, then crash and restart
    cyc(0, 1, 3'b001, 3'b000);
    run(256 * TD, 3'b001, 3'b000);
    chk("wrap_cnt",   32'(cnt),   32'd0);
    chk("wrap_score", 32'(score), 32'd0);
    run(33, 3'b010, 3'b010);
    chk("force_over", 32'(state), 32'b10);
    cyc(0, 1, 3'b010, 3'b010);
    chk("restart_state", 32'(state), 32'b01);
    chk("restart_field", 32'(field), 32'd0);
    chk("restart_cnt",   32'(cnt),   32'd0);

    // Reset lands on a tick cycle
    run(7, 3'b001, 3'b110);
    cyc(1, 0, 3'b001, 3'b110);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_field", 32'(field), 32'd0);

    // Random play
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          3'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/barrier_scroller.md
BARRIER_SCROLLER -- requirements
Module: barrier_scroller

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of playfield rows (2..16).
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clock cycles per scroll step (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, level; sampled each cycle, acted on only in IDLE or OVER.
REQ-006 SHALL have port player_pos, input, 3, one-hot player lane, bit2 = left, bit0 = right.
REQ-007 SHALL have port cnt, output, 8, registered index into the barrier pattern source.
REQ-008 SHALL have port barrier_in, input, 3, pattern source output for the current cnt, valid in the same cycle.
REQ-009 SHALL have port field, output, 3*ROWS, playfield; bits [2:0] = row 0 (top), bits [3*ROWS-1:3*ROWS-3] = bottom row.
REQ-010 SHALL have port state, output, 2, 00 IDLE, 01 RUN, 10 OVER.
REQ-011 SHALL have port hit, output, 1, one-cycle pulse on collision.
REQ-012 SHALL have port score, output, 16, count of barrier rows passed.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> OVER on collision; OVER -> RUN on start; encoding 11 unreachable and recovers to IDLE next cycle.
REQ-014 On start accepted (IDLE or OVER): the next cycle SHALL have field = 0, cnt = 0, score = 0, tick counter = 0, state = RUN.
REQ-015 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap; a tick occurs in the cycle the counter equals TICK_DIV-1. The first tick therefore occurs TICK_DIV cycles after entering RUN.
REQ-016 On a tick, each row r SHALL take row r-1, row 0 SHALL take barrier_in, and the old bottom row SHALL be discarded.
REQ-017 On a tick, cnt SHALL increment modulo 256 (255 -> 0).
REQ-018 On a tick, if the old bottom row is nonzero, score SHALL increment and saturate at 16'hFFFF.
REQ-019 Player lane: a register SHALL load player_pos only when it is one-hot; zero or multi-hot values SHALL be ignored and the previous lane held. The reset/start value is 3'b010.
REQ-020 Collision: in RUN, any cycle where (registered bottom row & player lane register) != 0 SHALL cause state = OVER and hit = 1 in the next cycle; hit SHALL be low in all other cycles.
REQ-021 If a collision and a tick occur in the same cycle, the collision SHALL win: no shift, no cnt increment, no score increment.
REQ-022 In IDLE and OVER, field, cnt, score and the tick counter SHALL hold their values.
REQ-023 start SHALL be ignored while in RUN.
REQ-024 All outputs SHALL be registered; no combinational path from barrier_in or player_pos to any output.

Reset
REQ-025 On rst = 1 at a clock edge: state = IDLE, field = 0, cnt = 0, score = 0, hit = 0, tick counter = 0, lane = 3'b010.
REQ-026 rst SHALL take priority over start, tick and collision in every state, including mid-RUN.

Verification (ROWS = 8, TICK_DIV = 4)
REQ-027 Reset scenario: rst for 2 cycles, then release -> state = 00, cnt = 0, field = 0, score = 0, hit = 0.
REQ-028 Dodge scenario: start; barrier_in held 3'b100; player_pos = 3'b001 -> after tick 8 the bottom row = 100; after tick 9 score = 1 and cnt = 9; hit is never asserted.
REQ-029 Collision scenario: as REQ-028 but player_pos = 3'b100 -> one cycle after the tick-8 update, hit = 1 and state = OVER; field and cnt are frozen at 8; score = 0.
REQ-030 Invalid lane scenario: player_pos = 3'b000, then 3'b011, with barrier_in = 3'b010 -> the held lane stays 010 and a collision occurs after tick 8.
REQ-031 Wrap and restart scenario: run 256 ticks with barrier_in = 0 -> cnt wraps to 0 and score = 0. Then force OVER, pulse start -> the next cycle shows state = RUN with all fields cleared.
REQ-032 Mid-run reset scenario: assert rst in the cycle of a tick during RUN -> the next cycle shows reset values and no shift.
